commit_trace_fifo: RTL and testbench

//  Consumes the IssueWidth-wide retire stream of core_model (update/pc/instr/reg/mem per lane)
//  and serialises it into a single-record-per-beat valid/ready trace port, lane 0 before lane 1.

---
 rtl/commit_trace_fifo.sv | 133 +++++++++++++
 tb/tb_commit_trace_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_fifo
// Brief    : Serialises a multi-lane retire stream into a one-record-per-beat
//            valid/ready trace port, with overflow drop and retire counters.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 16,
  parameter int XLEN        = 32
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [ISSUE_WIDTH-1:0]              update_i,
  input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    pc_i,
  input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    instr_i,
  input  logic [ISSUE_WIDTH-1:0][4:0]         reg_addr_i,
  input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    reg_data_i,
  input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    mem_addr_i,
  input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]    mem_data_i,
  input  logic [ISSUE_WIDTH-1:0]              mem_wrt_i,
  output logic                                almost_full_o,
  output logic                                rec_valid_o,
  input  logic                                rec_ready_i,
  output logic [XLEN-1:0]                     rec_pc_o,
  output logic [XLEN-1:0]                     rec_instr_o,
  output logic [4:0]                          rec_reg_addr_o,
  output logic [XLEN-1:0]                     rec_reg_data_o,
  output logic [XLEN-1:0]                     rec_mem_addr_o,
  output logic [XLEN-1:0]                     rec_mem_data_o,
  output logic                                rec_mem_wrt_o,
  output logic [63:0]                         retire_cnt_o,
  output logic [31:0]                         drop_cnt_o
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_IW    = c_CW'(ISSUE_WIDTH);

  logic [XLEN-1:0] r_pc       [DEPTH];
  logic [XLEN-1:0] r_instr    [DEPTH];
  logic [4:0]      r_reg_addr [DEPTH];
  logic [XLEN-1:0] r_reg_data [DEPTH];
  logic [XLEN-1:0] r_mem_addr [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic            r_mem_wrt  [DEPTH];

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [63:0]     r_retire_cnt;
  logic [31:0]     r_drop_cnt;

  logic [c_CW-1:0] w_n_in;
  logic [c_CW-1:0] w_free;
  logic [c_CW-1:0] w_count_next;
  logic [c_AW-1:0] w_widx [ISSUE_WIDTH];
  logic            w_accept;
  logic            w_pop;
  logic [32:0]     w_drop_sum;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
  // so retiring lanes are packed back-to-back in ascending lane order.
  always_comb begin
    w_n_in = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      w_widx[l] = r_wr_ptr + w_n_in[c_AW-1:0];
      if (update_i[l]) w_n_in = w_n_in + c_CW'(1);
    end
  end

  // Free space is judged on the pre-pop occupancy; a same-cycle pop cannot rescue a burst.
  assign w_free       = c_DEPTH - r_count;
  assign w_accept     = (w_n_in <= w_free);
  assign w_pop        = (r_count != '0) && rec_ready_i;
  assign w_count_next = r_count + (w_accept ? w_n_in : '0) - {{c_AW{1'b0}}, w_pop};
  assign w_drop_sum   = {1'b0, r_drop_cnt} + 33'(w_n_in);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_retire_cnt <= '0;
      r_drop_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]       <= '0;
        r_instr[i]    <= '0;
        r_reg_addr[i] <= '0;
        r_reg_data[i] <= '0;
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
        r_mem_wrt[i]  <= 1'b0;
      end
    end else begin
      if (w_accept) begin
        for (int l = 0; l < ISSUE_WIDTH; l++) begin
          if (update_i[l]) begin
            r_pc[w_widx[l]]       <= pc_i[l];
            r_instr[w_widx[l]]    <= instr_i[l];
            r_reg_addr[w_widx[l]] <= reg_addr_i[l];
            r_reg_data[w_widx[l]] <= reg_data_i[l];
            r_mem_addr[w_widx[l]] <= mem_addr_i[l];
            r_mem_data[w_widx[l]] <= mem_data_i[l];
            r_mem_wrt[w_widx[l]]  <= mem_wrt_i[l];
          end
        end
        r_wr_ptr     <= r_wr_ptr + w_n_in[c_AW-1:0];
        r_retire_cnt <= r_retire_cnt + 64'(w_n_in);
      end else begin
        r_drop_cnt <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= w_count_next;
    end
  end

  assign almost_full_o  = (w_free < c_IW);
  assign rec_valid_o    = (r_count != '0);
  assign rec_pc_o       = r_pc[r_rd_ptr];
  assign rec_instr_o    = r_instr[r_rd_ptr];
  assign rec_reg_addr_o = r_reg_addr[r_rd_ptr];
  assign rec_reg_data_o = r_reg_data[r_rd_ptr];
  assign rec_mem_addr_o = r_mem_addr[r_rd_ptr];
  assign rec_mem_data_o = r_mem_data[r_rd_ptr];
  assign rec_mem_wrt_o  = r_mem_wrt[r_rd_ptr];
  assign retire_cnt_o   = r_retire_cnt;
  assign drop_cnt_o     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_fifo
// Brief    : Directed scoreboard bench for commit_trace_fifo (DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_fifo;

  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [31:0] ma;
    logic [31:0] md;
    logic        mw;
  } rec_t;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [IW-1:0]             update;
  logic [IW-1:0][XLEN-1:0]   pc, instr, reg_data, mem_addr, mem_data;
  logic [IW-1:0][4:0]        reg_addr;
  logic [IW-1:0]             mem_wrt;
  logic                      rec_ready;
  logic                      almost_full, rec_valid, rec_mem_wrt;
  logic [XLEN-1:0]           rec_pc, rec_instr, rec_reg_data, rec_mem_addr, rec_mem_data;
  logic [4:0]                rec_reg_addr;
  logic [63:0]               retire_cnt;
  logic [31:0]               drop_cnt;

  rec_t sb[$];
  rec_t mon_act, mon_exp, t3_rec;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  commit_trace_fifo #(.ISSUE_WIDTH(IW), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rstn_i(rstn), .update_i(update),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_wrt_i(mem_wrt),
    .almost_full_o(almost_full), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_pc_o(rec_pc), .rec_instr_o(rec_instr), .rec_reg_data_o(rec_reg_data),
    .rec_mem_addr_o(rec_mem_addr), .rec_mem_data_o(rec_mem_data),
    .rec_reg_addr_o(rec_reg_addr), .rec_mem_wrt_o(rec_mem_wrt),
    .retire_cnt_o(retire_cnt), .drop_cnt_o(drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic rec_t mk(input logic [31:0] p);
    rec_t r;
    r.pc = p; r.instr = p ^ 32'h00A0_0093; r.ra = p[6:2];
    r.rd = p + 32'h1000; r.ma = 32'h0; r.md = 32'h0; r.mw = 1'b0;
    return r;
  endfunction

  task automatic set_lane(input int l, input rec_t r);
    pc[l] = r.pc; instr[l] = r.instr; reg_addr[l] = r.ra; reg_data[l] = r.rd;
    mem_addr[l] = r.ma; mem_data[l] = r.md; mem_wrt[l] = r.mw;
  endtask

  // One input cycle; expected records are queued only for bursts that should fit.
  task automatic cycle(input logic [1:0] upd, input rec_t r0, input rec_t r1, input bit acc);
    set_lane(0, r0);
    set_lane(1, r1);
    update = upd;
    if (acc) begin
      if (upd[0]) sb.push_back(r0);
      if (upd[1]) sb.push_back(r1);
    end
    @(posedge clk); #1;
    update = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every handshake beat must match the oldest expected record.
  always @(negedge clk) begin
    if (rstn && rec_valid && rec_ready) begin
      mon_act = '{rec_pc, rec_instr, rec_reg_addr, rec_reg_data, rec_mem_addr, rec_mem_data, rec_mem_wrt};
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL rec_beat: got pc=%h expected no record", rec_pc);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL rec_beat: got pc=%h instr=%h ra=%0d rd=%h ma=%h md=%h mw=%b expected pc=%h instr=%h ra=%0d rd=%h ma=%h md=%h mw=%b",
                      mon_act.pc, mon_act.instr, mon_act.ra, mon_act.rd, mon_act.ma, mon_act.md, mon_act.mw,
                      mon_exp.pc, mon_exp.instr, mon_exp.ra, mon_exp.rd, mon_exp.ma, mon_exp.md, mon_exp.mw);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rec_ready = 1'b0; update = '0;
    set_lane(0, '0); set_lane(1, '0);

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    check("t1_valid", 64'(rec_valid), 64'd0);
    check("t1_af", 64'(almost_full), 64'd0);
    check("t1_retire", retire_cnt, 64'd0);
    check("t1_drop", 64'(drop_cnt), 64'd0);
    check("t1_rec_a", {rec_pc, rec_instr}, 64'd0);
    check("t1_rec_b", {rec_reg_data, rec_mem_addr}, 64'd0);
    check("t1_rec_c", {26'd0, rec_mem_data, rec_reg_addr, rec_mem_wrt}, 64'd0);
    rstn = 1'b1;

    // T2 two-lane retire, lane 0 first
    rec_ready = 1'b1;
    cycle(2'b11, mk(32'h8000_0000), mk(32'h8000_0004), 1'b1);
    check("t2_valid_after_push", 64'(rec_valid), 64'd1);
    check("t2_head_pc", 64'(rec_pc), 64'h8000_0000);
    idle(3);
    check("t2_empty", 64'(rec_valid), 64'd0);
    check("t2_retire", retire_cnt, 64'd2);

    // T3 lane 1 only, store with register write
    t3_rec = '{32'h8000_0008, 32'h0012_A023, 5'd5, 32'h0000_1234, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1};
    rec_ready = 1'b0;
    cycle(2'b10, mk(32'h9000_0000), t3_rec, 1'b1);
    check("t3_mem_addr", 64'(rec_mem_addr), 64'h8000_0010);
    check("t3_reg_addr", 64'(rec_reg_addr), 64'd5);
    check("t3_mem_wrt", 64'(rec_mem_wrt), 64'd1);
    rec_ready = 1'b1;
    idle(2);
    check("t3_empty", 64'(rec_valid), 64'd0);
    check("t3_retire", retire_cnt, 64'd3);

    // T4 fill to DEPTH with sink stalled, then overflow
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cycle(2'b11, mk(32'h8000_1000 + 32'(16 * i)), mk(32'h8000_1008 + 32'(16 * i)), 1'b1);
    check("t4_af_after3", 64'(almost_full), 64'd0);
    cycle(2'b11, mk(32'h8000_1030), mk(32'h8000_1038), 1'b1);
    check("t4_af_after4", 64'(almost_full), 64'd1);
    cycle(2'b11, mk(32'h8000_1040), mk(32'h8000_1048), 1'b0);
    check("t4_drop", 64'(drop_cnt), 64'd2);
    check("t4_retire", retire_cnt, 64'd11);
    check("t4_head", 64'(rec_pc), 64'h8000_1000);
    rec_ready = 1'b1;
    idle(10);
    check("t4_empty", 64'(rec_valid), 64'd0);
    check("t4_af_empty", 64'(almost_full), 64'd0);

    // T5 count 7, pop and 2-lane push same cycle -> dropped, count 6
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cycle(2'b11, mk(32'h8000_2000 + 32'(16 * i)), mk(32'h8000_2008 + 32'(16 * i)), 1'b1);
    cycle(2'b01, mk(32'h8000_2030), mk(32'h0), 1'b1);
    check("t5_af_at7", 64'(almost_full), 64'd1);
    rec_ready = 1'b1;
    cycle(2'b11, mk(32'h8000_2040), mk(32'h8000_2048), 1'b0);
    check("t5_drop", 64'(drop_cnt), 64'd4);
    check("t5_af_at6", 64'(almost_full), 64'd0);
    check("t5_retire", retire_cnt, 64'd18);
    idle(8);
    check("t5_empty", 64'(rec_valid), 64'd0);

    // T6 reset with 5 buffered records, then normal operation
    rec_ready = 1'b0;
    cycle(2'b11, mk(32'h8000_3000), mk(32'h8000_3004), 1'b1);
    cycle(2'b11, mk(32'h8000_3008), mk(32'h8000_300C), 1'b1);
    cycle(2'b01, mk(32'h8000_3010), mk(32'h0), 1'b1);
    check("t6_valid_pre", 64'(rec_valid), 64'd1);
    rstn = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    check("t6_valid_rst", 64'(rec_valid), 64'd0);
    check("t6_retire_rst", retire_cnt, 64'd0);
    check("t6_drop_rst", 64'(drop_cnt), 64'd0);
    check("t6_pc_rst", 64'(rec_pc), 64'd0);
    rstn = 1'b1;
    rec_ready = 1'b1;
    cycle(2'b11, mk(32'h8000_4000), mk(32'h8000_4004), 1'b1);
    idle(3);
    check("t6_empty", 64'(rec_valid), 64'd0);
    check("t6_retire", retire_cnt, 64'd2);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
